// File: rtl/fanout_fork_buffer.sv
// Registered 1-to-N ready/valid fork: 2-entry buffer with per-branch "taken" tracking,
// so branches may accept the head word in different cycles and upstream ready never sees out_ready.
module fanout_fork_buffer #(
    parameter int unsigned NUM_OUT    = 7,
    parameter int unsigned DATA_WIDTH = 17
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_OUT-1:0]    cfg_en,
    input  logic [NUM_OUT-1:0]    cfg_sel,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_head;
    logic                  r_tail;
    logic [1:0]            r_count;
    logic [NUM_OUT-1:0]    r_done;

    logic [NUM_OUT-1:0]    w_active;
    logic [NUM_OUT-1:0]    w_take;
    logic                  w_nonempty;
    logic                  w_pop;
    logic                  w_push;

    always_comb begin
        w_active   = cfg_en & cfg_sel;
        w_nonempty = (r_count != 2'd0);
        out_valid  = {NUM_OUT{w_nonempty}} & w_active & ~r_done;
        w_take     = out_valid & out_ready;
        // Inactive branches count as done, so a branch dropped mid-word cannot stall the head.
        w_pop      = w_nonempty & (&(~w_active | r_done | out_ready));
        // Only registered state (plus reset) feeds upstream ready; a full buffer never pushes through.
        in_ready   = ~RESET & (r_count != 2'd2);
        w_push     = in_valid & in_ready;
        out_data   = r_mem[r_head];
        occupancy  = r_count;
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_tail] <= in_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            r_done  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
                r_done <= '0;
            end else begin
                r_done <= r_done | w_take;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

endmodule
